mem_sweep_checker: RTL and testbench

//  Read-back checker downstream of a public rw test memory (words indexed BASE..BASE+DEPTH-1).

---
 rtl/mem_sweep_checker.sv | 79 +++++++
 tb/tb_mem_sweep_checker.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_sweep_checker.sv
// mem_sweep_checker: sweeps a test memory from BASE+DEPTH-1 down to BASE, checking that each word equals its own index.
// Ports: clk/rst_n clock and async active-low reset; start_i/abort_i sweep control;
//   rd_en_o/rd_addr_o/rd_data_i memory read port (data one cycle after strobe);
//   busy_o/done_o/pass_o status; err_cnt_o/first_err_addr_o/first_err_data_o results.
module mem_sweep_checker #(
  parameter int DEPTH = 16,
  parameter int BASE  = 1,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          abort_i,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [DW-1:0] rd_data_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [CW-1:0] err_cnt_o,
  output logic [AW-1:0] first_err_addr_o,
  output logic [DW-1:0] first_err_data_o
);
  typedef enum logic [1:0] {IDLE, SWEEP, FLUSH, DONE} state_t;
  localparam logic [AW-1:0] TOP = AW'(BASE + DEPTH - 1);
  localparam logic [AW-1:0] BOT = AW'(BASE);
  state_t state, state_nx;
  logic [AW-1:0] addr_d;
  logic vld_d, err_seen, go, kill, mis;
  assign busy_o = state == SWEEP || state == FLUSH;
  assign pass_o = state == DONE && err_cnt_o == '0;
  assign go     = start_i && !abort_i && (state == IDLE || state == DONE);
  assign kill   = abort_i && busy_o;
  // the word read in the previous cycle is judged now, unless an abort discards it
  assign mis    = vld_d && !kill && rd_data_i != {{(DW-AW){1'b0}}, addr_d};
  always_comb begin
    state_nx = state;
    state_nx = kill ? IDLE :
               go ? SWEEP :
               (state == SWEEP && rd_addr_o == BOT) ? FLUSH :
               state == FLUSH ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rd_en_o          <= 1'b0;
      rd_addr_o        <= '0;
      addr_d           <= '0;
      vld_d            <= 1'b0;
      done_o           <= 1'b0;
      err_seen         <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
      first_err_data_o <= '0;
    end else begin
      state     <= state_nx;
      rd_en_o   <= state_nx == SWEEP;
      rd_addr_o <= go ? TOP : (state == SWEEP && !kill && rd_addr_o != BOT) ? rd_addr_o - AW'(1) : rd_addr_o;
      vld_d     <= rd_en_o && !kill;
      addr_d    <= rd_addr_o;
      done_o    <= state == FLUSH && !kill;
      if (go) begin
        err_seen         <= 1'b0;
        err_cnt_o        <= '0;
        first_err_addr_o <= '0;
        first_err_data_o <= '0;
      end else if (mis) begin
        err_cnt_o <= err_cnt_o + CW'(1);
        if (!err_seen) begin
          err_seen         <= 1'b1;
          first_err_addr_o <= addr_d;
          first_err_data_o <= rd_data_i;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_sweep_checker.sv
// tb_mem_sweep_checker: randomized self-checking bench for mem_sweep_checker against a memory-scan model.
module tb_mem_sweep_checker;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic rd_en, busy, done, pass;
  logic [4:0] rd_addr, err_cnt, fa;
  logic [31:0] rd_data, fd;
  logic [31:0] mem [0:31];
  logic        obs_en [0:40];
  logic [4:0]  obs_addr [0:40];
  int total = 0, passed = 0;

  mem_sweep_checker dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt),
    .first_err_addr_o(fa), .first_err_data_o(fd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic fill_ok();
    for (int i = 0; i < 32; i++) mem[i] = i;
  endtask

  task automatic model(output int cnt, output logic [31:0] ea, output logic [31:0] ed);
    cnt = 0; ea = 0; ed = 0;
    for (int a = 16; a >= 1; a--)
      if (mem[a] != a) begin
        if (cnt == 0) begin ea = a; ed = mem[a]; end
        cnt++;
      end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(output int dk);
    dk = -1;
    for (int k = 1; k <= 40 && dk < 0; k++) begin
      @(negedge clk);
      obs_en[k] = rd_en; obs_addr[k] = rd_addr;
      if (done) dk = k;
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({rd_en, rd_addr, busy, done, pass, err_cnt, fa, fd} !== '0)
      $display("FAIL reset_outputs got en=%b addr=%0d busy=%b done=%b pass=%b cnt=%0d fa=%0d fd=%0h want all 0", rd_en, rd_addr, busy, done, pass, err_cnt, fa, fd);
    else passed++;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_clean();
    int dk, bad;
    fill_ok();
    pulse_start(); wait_done(dk);
    total++; if (dk !== 18) $display("FAIL clean_done_cycle got %0d want 18", dk); else passed++;
    bad = 0;
    for (int k = 1; k <= 16; k++) if (obs_en[k] !== 1'b1 || obs_addr[k] !== 5'(17 - k)) bad++;
    total++; if (bad !== 0) $display("FAIL clean_addr_seq got %0d bad cycles want 0", bad); else passed++;
    total++; if ({obs_en[17], obs_addr[17]} !== {1'b0, 5'd1}) $display("FAIL clean_flush got en=%b addr=%0d want en=0 addr=1", obs_en[17], obs_addr[17]); else passed++;
    total++; if ({pass, err_cnt, busy} !== {1'b1, 5'd0, 1'b0}) $display("FAIL clean_result got pass=%b cnt=%0d busy=%b want 1 0 0", pass, err_cnt, busy); else passed++;
    @(negedge clk);
    total++; if ({done, pass} !== 2'b01) $display("FAIL clean_done_pulse got done=%b pass=%b want 0 1", done, pass); else passed++;
  endtask

  task automatic test_pattern(string name, int n_bad, int a0, logic [31:0] v0, int a1, logic [31:0] v1, bit zero);
    int dk, cnt;
    logic [31:0] ea, ed;
    fill_ok();
    if (zero) for (int i = 0; i < 32; i++) mem[i] = 0;
    if (n_bad > 0) mem[a0] = v0;
    if (n_bad > 1) mem[a1] = v1;
    model(cnt, ea, ed);
    pulse_start(); wait_done(dk);
    total++; if (dk !== 18) $display("FAIL %s_done got %0d want 18", name, dk); else passed++;
    total++;
    if ({err_cnt, fa, fd, pass} !== {5'(cnt), 5'(ea), ed, cnt == 0})
      $display("FAIL %s_result got cnt=%0d fa=%0d fd=%0h pass=%b want cnt=%0d fa=%0d fd=%0h pass=%b", name, err_cnt, fa, fd, pass, cnt, ea, ed, cnt == 0);
    else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int dk, cnt;
      logic [31:0] ea, ed;
      for (int i = 0; i < 32; i++) mem[i] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : i;
      model(cnt, ea, ed);
      pulse_start(); wait_done(dk);
      total++; if (dk !== 18) $display("FAIL rand%0d_done got %0d want 18", it, dk); else passed++;
      total++;
      if ({err_cnt, fa, fd, pass} !== {5'(cnt), 5'(ea), ed, cnt == 0})
        $display("FAIL rand%0d_result got cnt=%0d fa=%0d fd=%0h pass=%b want cnt=%0d fa=%0d fd=%0h", it, err_cnt, fa, fd, pass, cnt, ea, ed);
      else passed++;
    end
  endtask

  task automatic test_abort();
    int k9, dk, seen;
    fill_ok(); mem[14] = 3;
    pulse_start();
    k9 = -1;
    for (int k = 1; k <= 30 && k9 < 0; k++) begin
      @(negedge clk);
      start = rd_addr == 5'd12;
      if (rd_addr == 5'd9) begin abort = 1; k9 = k; end
    end
    @(posedge clk); #1 abort = 0; start = 0;
    total++; if (k9 !== 8) $display("FAIL abort_reach9 got cycle %0d want 8", k9); else passed++;
    @(negedge clk);
    total++; if ({busy, rd_en} !== 2'b00) $display("FAIL abort_idle got busy=%b en=%b want 0 0", busy, rd_en); else passed++;
    seen = 0;
    for (int k = 0; k < 25; k++) begin @(negedge clk); if (done || busy) seen++; end
    total++; if (seen !== 0) $display("FAIL abort_no_done got %0d active cycles want 0", seen); else passed++;
    fill_ok(); mem[5] = 77;
    pulse_start(); wait_done(dk);
    total++;
    if ({dk == 18, err_cnt, fa, fd, pass} !== {1'b1, 5'd1, 5'd5, 32'd77, 1'b0})
      $display("FAIL abort_restart got done_k=%0d cnt=%0d fa=%0d fd=%0d pass=%b want 18 1 5 77 0", dk, err_cnt, fa, fd, pass);
    else passed++;
  endtask

  task automatic test_async_reset();
    int act;
    fill_ok(); mem[16] = 0;
    pulse_start();
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    total++;
    if ({rd_en, rd_addr, busy, done, pass, err_cnt, fa, fd} !== '0)
      $display("FAIL async_reset got en=%b addr=%0d busy=%b cnt=%0d fa=%0d want all 0", rd_en, rd_addr, busy, err_cnt, fa);
    else passed++;
    @(negedge clk); rst_n = 1;
    act = 0;
    for (int k = 0; k < 25; k++) begin @(negedge clk); if (done || busy || rd_en) act++; end
    total++; if (act !== 0) $display("FAIL async_reset_idle got %0d active cycles want 0", act); else passed++;
  endtask

  task automatic test_back_to_back();
    int dk, dk2;
    fill_ok(); mem[10] = 3;
    pulse_start(); wait_done(dk);
    total++;
    if ({dk == 18, err_cnt, fa, fd} !== {1'b1, 5'd1, 5'd10, 32'd3})
      $display("FAIL b2b_first got done_k=%0d cnt=%0d fa=%0d fd=%0d want 18 1 10 3", dk, err_cnt, fa, fd);
    else passed++;
    mem[10] = 10; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done(dk2);
    total++; if ({obs_en[1], obs_addr[1]} !== {1'b1, 5'd16}) $display("FAIL b2b_restart got en=%b addr=%0d want 1 16", obs_en[1], obs_addr[1]); else passed++;
    total++;
    if ({dk2 == 18, err_cnt, fa, fd, pass} !== {1'b1, 5'd0, 5'd0, 32'd0, 1'b1})
      $display("FAIL b2b_second got done_k=%0d cnt=%0d fa=%0d fd=%0d pass=%b want 18 0 0 0 1", dk2, err_cnt, fa, fd, pass);
    else passed++;
  endtask

  initial begin
    fill_ok();
    test_reset();
    test_clean();
    test_pattern("one_err", 1, 7, 0, 0, 0, 0);
    test_pattern("all_zero", 0, 0, 0, 0, 0, 1);
    test_pattern("two_err", 2, 12, 5, 3, 9, 0);
    test_random();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
